// File: rtl/beep_driver.sv
// Burst beeper: drives a buzzer/LED pin with N timed pulses after a one-cycle start request.
// Define BEEP_TONE_EN to turn each ON phase into a square-wave tone for passive buzzers.
module beep_driver #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 25000000,
  parameter int CNT_W      = 4,
  parameter int TONE_HALF  = 25000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             beep_out
);

  localparam int MAX_PHASE = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYC   = (MAX_PHASE > TONE_HALF) ? MAX_PHASE : TONE_HALF;
  localparam int TMR_W     = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef BEEP_TONE_EN
  localparam logic [TMR_W-1:0] TONE_LOAD = TMR_W'(TONE_HALF);
`endif

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  state_t           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] remaining_q;
  logic             busy_q;
  logic             done_q;
  logic             beep_q;
`ifdef BEEP_TONE_EN
  logic [TMR_W-1:0] tone_q;
`endif

  // Phase timer is loaded with the phase length and counts down to 1; the
  // transition happens in the cycle where it reads 1, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beep_q      <= 1'b0;
`ifdef BEEP_TONE_EN
      tone_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop && (count != '0)) begin
            state_q     <= ON;
            timer_q     <= ON_LOAD;
            remaining_q <= count;
            busy_q      <= 1'b1;
            beep_q      <= 1'b1;
`ifdef BEEP_TONE_EN
            tone_q      <= TONE_LOAD;
`endif
          end
        end

        ON: begin
          if (stop) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            beep_q      <= 1'b0;
          end else if (timer_q == TMR_ONE) begin
            remaining_q <= remaining_q - CNT_ONE;
            beep_q      <= 1'b0;
            // Last beep ends straight in IDLE: no trailing silence before done.
            if (remaining_q == CNT_ONE) begin
              state_q <= IDLE;
              timer_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= OFF;
              timer_q <= OFF_LOAD;
            end
          end else begin
            timer_q <= timer_q - TMR_ONE;
`ifdef BEEP_TONE_EN
            if (tone_q == TMR_ONE) begin
              tone_q <= TONE_LOAD;
              beep_q <= ~beep_q;
            end else begin
              tone_q <= tone_q - TMR_ONE;
            end
`endif
          end
        end

        OFF: begin
          if (stop) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
          end else if (timer_q == TMR_ONE) begin
            state_q <= ON;
            timer_q <= ON_LOAD;
            beep_q  <= 1'b1;
`ifdef BEEP_TONE_EN
            tone_q  <= TONE_LOAD;
`endif
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end

        default: begin
          state_q     <= IDLE;
          timer_q     <= '0;
          remaining_q <= '0;
          busy_q      <= 1'b0;
          beep_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign beep_out = beep_q;

endmodule

// File: tb/tb_beep_driver.sv
// Directed bench for beep_driver: bursts, ignored starts, stop/abort, async reset.
// With BEEP_TONE_EN defined it runs the tone configuration and checks the square wave.
module tb_beep_driver;

`ifdef BEEP_TONE_EN
  localparam int ON_C  = 8;
`else
  localparam int ON_C  = 4;
`endif
  localparam int OFF_C = 3;
  localparam int CW    = 4;
  localparam int TH    = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] count;
  logic          stop;
  logic          busy;
  logic          done;
  logic          beep_out;

  int checkCount = 0;
  int failCount  = 0;

  beep_driver #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .CNT_W     (CW),
    .TONE_HALF (TH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .count   (count),
    .stop    (stop),
    .busy    (busy),
    .done    (done),
    .beep_out(beep_out)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [CW-1:0] c, input logic p);
    start = s;
    count = c;
    stop  = p;
  endtask

  // Advance to the next cycle and settle past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] observedBits();
    return {29'd0, busy, done, beep_out};
  endfunction

  // Expected {busy,done,beep_out} in cycle c of an n-beep burst started in cycle 0.
  function automatic logic [31:0] expectedBits(int n, int c);
    int lastCycle;
    int pos;
    logic b;
    lastCycle = n * ON_C + (n - 1) * OFF_C;
    if (c >= 1 && c <= lastCycle) begin
      pos = (c - 1) % (ON_C + OFF_C);
      b = (pos < ON_C);
`ifdef BEEP_TONE_EN
      b = b && (((pos / TH) % 2) == 0);
`endif
      return {29'd0, 1'b1, 1'b0, b};
    end
    if (c == lastCycle + 1) return 32'h2;
    return 32'h0;
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_values", observedBits(), 32'h0);
    rst = 1'b0;
    tick();

    // Plain two-beep burst.
    applyStimulus(1'b1, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= 2 * (ON_C + OFF_C); c++) begin
      checkOutput($sformatf("burst2_c%0d", c), observedBits(), expectedBits(2, c));
      tick();
    end

    // Start with count zero is ignored.
    applyStimulus(1'b1, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      checkOutput($sformatf("count0_c%0d", c), observedBits(), 32'h0);
      tick();
    end

    // Second start while busy must not resample the count.
    applyStimulus(1'b1, 4'd3, 1'b0);
    tick();
    for (int c = 1; c <= 3 * (ON_C + OFF_C) + 4; c++) begin
      checkOutput($sformatf("busystart_c%0d", c), observedBits(), expectedBits(3, c));
      if (c == 6) applyStimulus(1'b1, 4'd1, 1'b0);
      else applyStimulus(1'b0, '0, 1'b0);
      tick();
    end

    // Stop mid-burst aborts without done.
    applyStimulus(1'b1, 4'd5, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      checkOutput($sformatf("stop_c%0d", c), observedBits(), (c <= 6) ? expectedBits(5, c) : 32'h0);
      if (c == 6) applyStimulus(1'b0, '0, 1'b1);
      else applyStimulus(1'b0, '0, 1'b0);
      tick();
    end

    // Stop and start together in IDLE: stop wins.
    applyStimulus(1'b1, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("stopstart_c%0d", c), observedBits(), 32'h0);
      tick();
    end

    // Stop on the final ON cycle suppresses done.
    applyStimulus(1'b1, 4'd1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= ON_C + 4; c++) begin
      checkOutput($sformatf("laststop_c%0d", c), observedBits(), (c <= ON_C) ? expectedBits(1, c) : 32'h0);
      if (c == ON_C) applyStimulus(1'b0, '0, 1'b1);
      else applyStimulus(1'b0, '0, 1'b0);
      tick();
    end

    // Asynchronous reset during an active beep, then a fresh burst.
    applyStimulus(1'b1, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("prerst_c%0d", c), observedBits(), expectedBits(2, c));
      if (c < 3) tick();
    end
    rst = 1'b1;
    #1;
    checkOutput("async_rst", observedBits(), 32'h0);
    tick();
    checkOutput("rst_held", observedBits(), 32'h0);
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= 2 * (ON_C + OFF_C); c++) begin
      checkOutput($sformatf("postrst_c%0d", c), observedBits(), expectedBits(2, c));
      tick();
    end

`ifdef BEEP_TONE_EN
    // Single tone beep: 1,1,0,0,1,1,0,0 then done.
    applyStimulus(1'b1, 4'd1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    for (int c = 1; c <= ON_C + 3; c++) begin
      checkOutput($sformatf("tone_c%0d", c), observedBits(), expectedBits(1, c));
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
